lsu_mem_stage: RTL



---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_lane_align.sv | 71 +++++++
 rtl/lsu_mem_stage.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the sizing helper for the bus timeout counter.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // Bits needed to count 0..n; never less than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the word bus: byte enables and store replication on
// the request side, lane extraction and sign/zero extension on the load side.
import lsu_pkg::*;

module lsu_lane_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_value
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Request side: enables follow the access size, data is replicated per lane.
  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      F3_W: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      default: begin
        be    = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

  // Load side: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    ld_value = 32'h0000_0000;
    case (ld_addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (ld_addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (ld_funct3)
      F3_B:    ld_value = {{24{byte_s[7]}}, byte_s};
      F3_BU:   ld_value = {24'h00_0000, byte_s};
      F3_H:    ld_value = {{16{half_s[15]}}, half_s};
      F3_HU:   ld_value = {16'h0000, half_s};
      F3_W:    ld_value = rdata;
      default: ld_value = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the single-cycle RV32I core: drives one handshaked word-bus
// access per load/store and stalls the core until it completes.
// Define MISALIGN_CHECK_EN to reject misaligned H/W accesses with access_err.
import lsu_pkg::*;

module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              access_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int                 CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        ld_f3_r;
  logic [1:0]        ld_lo_r;
  logic [31:0]       load_data_r;
  logic              access_err_r;
  logic              bus_req_r;
  logic              bus_we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [3:0]        bus_be_r;
  logic [31:0]       bus_wdata_r;

  logic              op_s;
  logic              legal_s;
  logic              misalign_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [31:0]       ld_value_s;

  lsu_lane_align u_align (
    .funct3     (funct3),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .ld_funct3  (ld_f3_r),
    .ld_addr_lo (ld_lo_r),
    .rdata      (bus_rdata),
    .be         (be_s),
    .wdata      (wdata_s),
    .ld_value   (ld_value_s)
  );

  // Decode whether the presented op may be issued on the bus.
  always_comb begin
    op_s    = mem_read | mem_write;
    legal_s = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: legal_s = 1'b1;
      F3_BU, F3_HU:     legal_s = mem_read;
      default:          legal_s = 1'b0;
    endcase
`ifdef MISALIGN_CHECK_EN
    misalign_s = (((funct3 == F3_H) || (funct3 == F3_HU)) && addr[0]) ||
                 ((funct3 == F3_W) && (addr[1:0] != 2'b00));
`else
    misalign_s = 1'b0;
`endif
  end

  // The core may advance only once the access has finished (DONE) or failed (ERR).
  assign stall = op_s & ((state_r == IDLE) | (state_r == BUSY));

  // Access sequencer: issue, wait for ack or timeout, report, return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= '0;
      ld_f3_r      <= 3'b000;
      ld_lo_r      <= 2'b00;
      load_data_r  <= 32'h0000_0000;
      access_err_r <= 1'b0;
      bus_req_r    <= 1'b0;
      bus_we_r     <= 1'b0;
      bus_addr_r   <= '0;
      bus_be_r     <= 4'b0000;
      bus_wdata_r  <= 32'h0000_0000;
    end else begin
      access_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (op_s) begin
            if (legal_s && !misalign_s) begin
              bus_req_r   <= 1'b1;
              bus_we_r    <= mem_write;
              bus_addr_r  <= {addr[ADDR_W-1:2], 2'b00};
              bus_be_r    <= be_s;
              bus_wdata_r <= wdata_s;
              ld_f3_r     <= funct3;
              ld_lo_r     <= addr[1:0];
              cnt_r       <= '0;
              state_r     <= BUSY;
            end else begin
              access_err_r <= 1'b1;
              state_r      <= ERR;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          // An ack in the last allowed cycle still completes the access.
          if (bus_ack) begin
            bus_req_r <= 1'b0;
            if (!bus_we_r) begin
              load_data_r <= ld_value_s;
            end
            state_r <= DONE;
          end else if (cnt_r == CNT_LAST) begin
            bus_req_r    <= 1'b0;
            access_err_r <= 1'b1;
            cnt_r        <= '0;
            state_r      <= ERR;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE:    state_r <= IDLE;
        ERR:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign load_data  = load_data_r;
  assign access_err = access_err_r;
  assign bus_req    = bus_req_r;
  assign bus_we     = bus_we_r;
  assign bus_addr   = bus_addr_r;
  assign bus_be     = bus_be_r;
  assign bus_wdata  = bus_wdata_r;

endmodule
